// File: rtl/pktunit_egress_arbiter.sv
// Round-robin egress arbiter: merges NUM_SRC flags/data/eop packet streams into one,
// holding the grant from the flags token through the end-of-packet beat.
module pktunit_egress_arbiter #(
    parameter int DATA_BYTES = 8,
    parameter int NUM_SRC    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_BYTES*8-1:0] src_data_d  [NUM_SRC],
    input  logic                    src_data_v  [NUM_SRC],
    output logic                    src_data_r  [NUM_SRC],
    input  logic [7:0]              src_flags_d [NUM_SRC],
    input  logic                    src_flags_v [NUM_SRC],
    output logic                    src_flags_r [NUM_SRC],
    input  logic [DATA_BYTES-1:0]   src_eop_d   [NUM_SRC],
    input  logic                    src_eop_v   [NUM_SRC],
    output logic                    src_eop_r   [NUM_SRC],
    output logic [DATA_BYTES*8-1:0] out_data_d,
    output logic                    out_data_v,
    input  logic                    out_data_r,
    output logic [7:0]              out_flags_d,
    output logic                    out_flags_v,
    input  logic                    out_flags_r,
    output logic [DATA_BYTES-1:0]   out_eop_d,
    output logic                    out_eop_v,
    input  logic                    out_eop_r,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic [31:0]             pkt_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_FLAGS, ST_BURST} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_grant;
    logic [2:0]              r_last_grant;
    logic [31:0]             r_pkt_cnt;
    logic [2:0]              w_pick;
    logic                    w_any_req;
    logic [DATA_BYTES*8-1:0] w_g_data_d;
    logic                    w_g_data_v;
    logic [7:0]              w_g_flags_d;
    logic                    w_g_flags_v;
    logic [DATA_BYTES-1:0]   w_g_eop_d;
    logic                    w_g_eop_v;
    logic                    w_beat_v;
    logic                    w_beat_xfer;
    logic                    w_last_beat;

    always_comb begin
        w_g_data_d  = '0;
        w_g_data_v  = 1'b0;
        w_g_flags_d = '0;
        w_g_flags_v = 1'b0;
        w_g_eop_d   = '0;
        w_g_eop_v   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == 3'(i)) begin
                w_g_data_d  = src_data_d[i];
                w_g_data_v  = src_data_v[i];
                w_g_flags_d = src_flags_d[i];
                w_g_flags_v = src_flags_v[i];
                w_g_eop_d   = src_eop_d[i];
                w_g_eop_v   = src_eop_v[i];
            end
        end
    end

    // Scan offsets 1..NUM_SRC from last_grant; the second term handles wrap past NUM_SRC-1.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!w_any_req && src_flags_v[j] &&
                    ((int'(r_last_grant) + k == j) || (int'(r_last_grant) + k == j + NUM_SRC))) begin
                    w_any_req = 1'b1;
                    w_pick    = 3'(j);
                end
            end
        end
    end

    assign w_beat_v    = w_g_data_v & w_g_eop_v;
    assign w_last_beat = |w_g_eop_d;

    always_comb begin
        w_state_nxt = r_state;
        out_flags_v = 1'b0;
        out_data_v  = 1'b0;
        out_eop_v   = 1'b0;
        w_beat_xfer = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_flags_r[i] = 1'b0;
            src_data_r[i]  = 1'b0;
            src_eop_r[i]   = 1'b0;
        end
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) w_state_nxt = ST_FLAGS;
                end
                ST_FLAGS: begin
                    out_flags_v = w_g_flags_v;
                    for (int i = 0; i < NUM_SRC; i++)
                        if (r_grant == 3'(i)) src_flags_r[i] = out_flags_r;
                    if (w_g_flags_v && out_flags_r) w_state_nxt = ST_BURST;
                end
                ST_BURST: begin
                    out_data_v  = w_beat_v;
                    out_eop_v   = w_beat_v;
                    w_beat_xfer = w_beat_v & out_data_r & out_eop_r;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (r_grant == 3'(i)) begin
                            src_data_r[i] = w_beat_xfer;
                            src_eop_r[i]  = w_beat_xfer;
                        end
                    end
                    if (w_beat_xfer && w_last_beat) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= 3'(NUM_SRC - 1);
            r_pkt_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_req) r_grant <= w_pick;
            if (r_state == ST_BURST && w_beat_xfer && w_last_beat) begin
                r_last_grant <= r_grant;
                r_pkt_cnt    <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign out_data_d  = w_g_data_d;
    assign out_flags_d = w_g_flags_d;
    assign out_eop_d   = w_g_eop_d;
    assign grant_id    = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_pktunit_egress_arbiter.sv
// Directed bench for pktunit_egress_arbiter: arbitration order, flags/burst handshakes,
// back-pressure, eop lag, mid-packet reset and packet counter wrap.
module tb_pktunit_egress_arbiter;

    localparam int DB = 8;
    localparam int NS = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [DB*8-1:0] src_data_d  [NS];
    logic            src_data_v  [NS];
    logic            src_data_r  [NS];
    logic [7:0]      src_flags_d [NS];
    logic            src_flags_v [NS];
    logic            src_flags_r [NS];
    logic [DB-1:0]   src_eop_d   [NS];
    logic            src_eop_v   [NS];
    logic            src_eop_r   [NS];
    logic [DB*8-1:0] out_data_d;
    logic            out_data_v;
    logic            out_data_r;
    logic [7:0]      out_flags_d;
    logic            out_flags_v;
    logic            out_flags_r;
    logic [DB-1:0]   out_eop_d;
    logic            out_eop_v;
    logic            out_eop_r;
    logic [2:0]      grant_id;
    logic            busy;
    logic [31:0]     pkt_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pktunit_egress_arbiter #(.DATA_BYTES(DB), .NUM_SRC(NS)) dut (
        .clk(clk), .rst(rst),
        .src_data_d(src_data_d), .src_data_v(src_data_v), .src_data_r(src_data_r),
        .src_flags_d(src_flags_d), .src_flags_v(src_flags_v), .src_flags_r(src_flags_r),
        .src_eop_d(src_eop_d), .src_eop_v(src_eop_v), .src_eop_r(src_eop_r),
        .out_data_d(out_data_d), .out_data_v(out_data_v), .out_data_r(out_data_r),
        .out_flags_d(out_flags_d), .out_flags_v(out_flags_v), .out_flags_r(out_flags_r),
        .out_eop_d(out_eop_d), .out_eop_v(out_eop_v), .out_eop_r(out_eop_r),
        .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] bd(int s, int b);
        return {8'hD0, 48'h0, 4'(s), 4'(b)};
    endfunction

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            src_data_d[i]  = '0;
            src_data_v[i]  = 1'b0;
            src_flags_d[i] = '0;
            src_flags_v[i] = 1'b0;
            src_eop_d[i]   = '0;
            src_eop_v[i]   = 1'b0;
        end
    endtask

    task automatic drive_beat(int s, int b, logic [7:0] eop);
        src_data_d[s] = bd(s, b);
        src_data_v[s] = 1'b1;
        src_eop_d[s]  = eop;
        src_eop_v[s]  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_src();
        out_data_r = 1'b1; out_flags_r = 1'b1; out_eop_r = 1'b1;
        src_flags_v[0] = 1'b1;
        drive_beat(0, 0, 8'h01);
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (pkt_cnt !== 32'd0) $display("FAIL reset pkt_cnt: got %0d want 0", pkt_cnt); else n_pass++;
        n_total++; if (grant_id !== 3'd0) $display("FAIL reset grant_id: got %0d want 0", grant_id); else n_pass++;
        n_total++; if (out_flags_v !== 1'b0) $display("FAIL reset out_flags_v: got %0b want 0", out_flags_v); else n_pass++;
        n_total++; if (src_flags_r[0] !== 1'b0) $display("FAIL reset src_flags_r0: got %0b want 0", src_flags_r[0]); else n_pass++;
        n_total++; if (out_data_v !== 1'b0) $display("FAIL reset out_data_v: got %0b want 0", out_data_v); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        clear_src();
    endtask

    task automatic test_single_source();
        src_flags_v[1] = 1'b1;
        src_flags_d[1] = 8'h5A;
        drive_beat(1, 0, 8'h00);
        #1;
        n_total++; if (src_flags_r[1] !== 1'b0) $display("FAIL idle src_flags_r1: got %0b want 0", src_flags_r[1]); else n_pass++;
        n_total++; if (out_flags_v !== 1'b0) $display("FAIL idle out_flags_v: got %0b want 0", out_flags_v); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (busy !== 1'b1) $display("FAIL flags busy: got %0b want 1", busy); else n_pass++;
        n_total++; if (grant_id !== 3'd1) $display("FAIL flags grant_id: got %0d want 1", grant_id); else n_pass++;
        n_total++; if (out_flags_v !== 1'b1) $display("FAIL flags out_flags_v: got %0b want 1", out_flags_v); else n_pass++;
        n_total++; if (out_flags_d !== 8'h5A) $display("FAIL flags out_flags_d: got %h want 5a", out_flags_d); else n_pass++;
        n_total++; if (src_flags_r[1] !== 1'b1) $display("FAIL flags src_flags_r1: got %0b want 1", src_flags_r[1]); else n_pass++;
        n_total++; if (src_data_r[1] !== 1'b0) $display("FAIL flags src_data_r1: got %0b want 0", src_data_r[1]); else n_pass++;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            src_flags_v[1] = 1'b0;
            drive_beat(1, b, (b == 3) ? 8'h80 : 8'h00);
            #1;
            n_total++; if (out_data_v !== 1'b1) $display("FAIL beat%0d out_data_v: got %0b want 1", b, out_data_v); else n_pass++;
            n_total++; if (out_data_d !== bd(1, b)) $display("FAIL beat%0d out_data_d: got %h want %h", b, out_data_d, bd(1, b)); else n_pass++;
            n_total++; if (src_data_r[1] !== 1'b1) $display("FAIL beat%0d src_data_r1: got %0b want 1", b, src_data_r[1]); else n_pass++;
            n_total++; if (src_flags_r[1] !== 1'b0) $display("FAIL beat%0d src_flags_r1: got %0b want 0", b, src_flags_r[1]); else n_pass++;
        end
        @(negedge clk);
        clear_src();
        #1;
        n_total++; if (pkt_cnt !== 32'd1) $display("FAIL single pkt_cnt: got %0d want 1", pkt_cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL single busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (grant_id !== 3'd1) $display("FAIL single grant_id: got %0d want 1", grant_id); else n_pass++;
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < NS; s++) begin
            src_flags_v[s] = 1'b1;
            src_flags_d[s] = 8'h10 + 8'(s);
            drive_beat(s, 0, 8'h01);
        end
        for (int p = 0; p < NS; p++) begin
            @(negedge clk); #1;
            n_total++; if (grant_id !== 3'(p)) $display("FAIL rr%0d grant_id: got %0d want %0d", p, grant_id, p); else n_pass++;
            n_total++; if (out_flags_d !== 8'h10 + 8'(p)) $display("FAIL rr%0d out_flags_d: got %h want %h", p, out_flags_d, 8'h10 + 8'(p)); else n_pass++;
            @(negedge clk); #1;
            n_total++; if (out_data_d !== bd(p, 0)) $display("FAIL rr%0d out_data_d: got %h want %h", p, out_data_d, bd(p, 0)); else n_pass++;
            @(negedge clk);
            src_flags_v[p] = 1'b0;
            src_data_v[p]  = 1'b0;
            src_eop_v[p]   = 1'b0;
            #1;
            n_total++; if (pkt_cnt !== 32'(p + 1)) $display("FAIL rr%0d pkt_cnt: got %0d want %0d", p, pkt_cnt, p + 1); else n_pass++;
            n_total++; if (busy !== 1'b0) $display("FAIL rr%0d busy: got %0b want 0", p, busy); else n_pass++;
        end
        for (int s = 0; s < 2; s++) begin
            src_flags_v[s] = 1'b1;
            drive_beat(s, 1, 8'h01);
        end
        @(negedge clk); #1;
        n_total++; if (grant_id !== 3'd0) $display("FAIL rr wrap grant_id: got %0d want 0", grant_id); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        clear_src();
        #1;
        n_total++; if (pkt_cnt !== 32'd4) $display("FAIL rr wrap pkt_cnt: got %0d want 4", pkt_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int idx;
        idx = 0;
        src_flags_v[2] = 1'b1;
        src_flags_d[2] = 8'h33;
        drive_beat(2, 0, 8'h00);
        @(negedge clk); #1;
        n_total++; if (grant_id !== 3'd2) $display("FAIL bp grant_id: got %0d want 2", grant_id); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            src_flags_v[2] = 1'b0;
            out_data_r = ((c % 2) == 0);
            drive_beat(2, idx, (idx == 2) ? 8'h04 : 8'h00);
            #1;
            n_total++; if (out_data_v !== 1'b1) $display("FAIL bp c%0d out_data_v: got %0b want 1", c, out_data_v); else n_pass++;
            n_total++; if (out_data_d !== bd(2, idx)) $display("FAIL bp c%0d out_data_d: got %h want %h", c, out_data_d, bd(2, idx)); else n_pass++;
            n_total++; if (src_data_r[2] !== out_data_r) $display("FAIL bp c%0d src_data_r2: got %0b want %0b", c, src_data_r[2], out_data_r); else n_pass++;
            n_total++; if (src_eop_r[2] !== out_data_r) $display("FAIL bp c%0d src_eop_r2: got %0b want %0b", c, src_eop_r[2], out_data_r); else n_pass++;
            if (out_data_r) idx++;
        end
        @(negedge clk);
        clear_src();
        out_data_r = 1'b1;
        #1;
        n_total++; if (pkt_cnt !== 32'd5) $display("FAIL bp pkt_cnt: got %0d want 5", pkt_cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL bp busy: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_eop_lag();
        logic e;
        src_flags_v[0] = 1'b1;
        src_flags_d[0] = 8'h44;
        src_data_d[0]  = bd(0, 0);
        src_data_v[0]  = 1'b1;
        src_eop_d[0]   = 8'h01;
        src_eop_v[0]   = 1'b0;
        @(negedge clk); #1;
        n_total++; if (grant_id !== 3'd0) $display("FAIL lag grant_id: got %0d want 0", grant_id); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            src_flags_v[0] = 1'b0;
            e = (c == 2);
            src_eop_v[0] = e;
            #1;
            n_total++; if (out_data_v !== e) $display("FAIL lag c%0d out_data_v: got %0b want %0b", c, out_data_v, e); else n_pass++;
            n_total++; if (out_eop_v !== e) $display("FAIL lag c%0d out_eop_v: got %0b want %0b", c, out_eop_v, e); else n_pass++;
            n_total++; if (src_data_r[0] !== e) $display("FAIL lag c%0d src_data_r0: got %0b want %0b", c, src_data_r[0], e); else n_pass++;
            n_total++; if (src_eop_r[0] !== e) $display("FAIL lag c%0d src_eop_r0: got %0b want %0b", c, src_eop_r[0], e); else n_pass++;
        end
        @(negedge clk);
        clear_src();
        #1;
        n_total++; if (pkt_cnt !== 32'd6) $display("FAIL lag pkt_cnt: got %0d want 6", pkt_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        src_flags_v[1] = 1'b1;
        drive_beat(1, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        src_flags_v[1] = 1'b0;
        #1;
        n_total++; if (out_data_d !== bd(1, 0)) $display("FAIL mid beat0 out_data_d: got %h want %h", out_data_d, bd(1, 0)); else n_pass++;
        @(negedge clk);
        drive_beat(1, 1, 8'h00);
        rst = 1'b1;
        #1;
        n_total++; if (out_data_v !== 1'b0) $display("FAIL mid rst out_data_v: got %0b want 0", out_data_v); else n_pass++;
        n_total++; if (src_data_r[1] !== 1'b0) $display("FAIL mid rst src_data_r1: got %0b want 0", src_data_r[1]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        clear_src();
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL mid busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (pkt_cnt !== 32'd0) $display("FAIL mid pkt_cnt: got %0d want 0", pkt_cnt); else n_pass++;
        src_flags_v[2] = 1'b1;
        src_flags_d[2] = 8'h77;
        drive_beat(2, 0, 8'h03);
        @(negedge clk); #1;
        n_total++; if (grant_id !== 3'd2) $display("FAIL mid regrant grant_id: got %0d want 2", grant_id); else n_pass++;
        @(negedge clk);
        src_flags_v[2] = 1'b0;
        #1;
        n_total++; if (out_eop_d !== 8'h03) $display("FAIL mid out_eop_d: got %h want 03", out_eop_d); else n_pass++;
        n_total++; if (out_eop_v !== 1'b1) $display("FAIL mid out_eop_v: got %0b want 1", out_eop_v); else n_pass++;
        @(negedge clk);
        clear_src();
        #1;
        n_total++; if (pkt_cnt !== 32'd1) $display("FAIL mid multi-bit eop pkt_cnt: got %0d want 1", pkt_cnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mid final busy: got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_pkt_cnt_wrap();
        force dut.r_pkt_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_pkt_cnt;
        n_total++; if (pkt_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap preload pkt_cnt: got %h want ffffffff", pkt_cnt); else n_pass++;
        src_flags_v[0] = 1'b1;
        drive_beat(0, 0, 8'h80);
        @(negedge clk);
        @(negedge clk);
        src_flags_v[0] = 1'b0;
        @(negedge clk);
        clear_src();
        #1;
        n_total++; if (pkt_cnt !== 32'd0) $display("FAIL wrap pkt_cnt: got %h want 0", pkt_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_eop_lag();
        test_reset_mid_packet();
        test_pkt_cnt_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pktunit_egress_arbiter.md
PKTUNIT_EGRESS_ARBITER -- requirements
Module: pktunit_egress_arbiter

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8: bytes per data beat; eop_d width.
REQ-002 SHALL have parameter NUM_SRC, default 3: number of source packet streams; legal range 2..8.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports src_data_d / src_data_v / src_data_r, in/in/out, unpacked [NUM_SRC] of DATA_BYTES*8 / 1 / 1: per-source data channel.
REQ-006 SHALL have ports src_flags_d / src_flags_v / src_flags_r, in/in/out, [NUM_SRC] of 8 / 1 / 1: per-source flags channel, one token per packet.
REQ-007 SHALL have ports src_eop_d / src_eop_v / src_eop_r, in/in/out, [NUM_SRC] of DATA_BYTES / 1 / 1: per-source eop channel, one token per data beat; nonzero marks the last beat.
REQ-008 SHALL have ports out_data_d/v/r, out_flags_d/v/r and out_eop_d/v/r, mirroring one source with opposite directions: merged stream to the poller.
REQ-009 SHALL have port grant_id, output, 3: index of the currently granted source.
REQ-010 SHALL have port busy, output, 1: high in FLAGS or BURST.
REQ-011 SHALL have port pkt_cnt, output, 32: number of packets forwarded.

Function
REQ-012 SHALL implement FSM states IDLE, FLAGS and BURST.
REQ-013 In IDLE, if any src_flags_v is high, SHALL register the first requester scanning from (last_grant+1) mod NUM_SRC upward with wrap, then SHALL move to FLAGS on the next edge.
REQ-014 In IDLE, all src_*_r and all out_*_v SHALL be 0.
REQ-015 In FLAGS, out_flags_d/v SHALL equal src_flags_d/v[grant_id] and src_flags_r[grant_id] SHALL equal out_flags_r, combinationally.
REQ-016 In FLAGS, a flags handshake SHALL move the FSM to BURST; with no handshake it SHALL stay in FLAGS indefinitely.
REQ-017 In BURST, out_data_v and out_eop_v SHALL both equal src_data_v[g] AND src_eop_v[g], where g is grant_id.
REQ-018 In BURST, src_data_r[g] and src_eop_r[g] SHALL both equal out_data_r AND out_eop_r AND src_data_v[g] AND src_eop_v[g], so data and eop transfer jointly as one beat.
REQ-019 out_data_d and out_eop_d SHALL be a combinational pass-through of source g, giving zero cycles of beat latency.
REQ-020 A beat with eop_d != 0 in BURST SHALL, on the same edge, set last_grant to g, increment pkt_cnt and return the FSM to IDLE.
REQ-021 Ready SHALL be 0 on every channel of non-granted sources, and on the flags channel during BURST and the data/eop channels during FLAGS.
REQ-022 A packet SHALL never be interleaved with another source; the grant SHALL be held from the flags handshake to the eop beat.
REQ-023 pkt_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 A single-beat packet SHALL take exactly 3 cycles per packet under full readiness: IDLE, FLAGS, BURST.
REQ-025 A requester dropping flags_v while in IDLE SHALL not be granted; its grant is registered only if flags_v is high on the arbitration edge.
REQ-026 eop_d values with multiple bits set SHALL be forwarded unchanged and treated as end-of-packet.

Reset
REQ-027 On rst=1 at a clock edge, state SHALL become IDLE, last_grant NUM_SRC-1, grant_id 0, busy 0 and pkt_cnt 0; this applies mid-packet too, abandoning the packet.
REQ-028 While rst=1, all out_*_v and src_*_r SHALL be 0.

Verification
REQ-029 Source 1 only, 4-beat packet with flags 0x5A and eop 0,0,0,0x80, sink always ready -> out flags 0x5A, 4 beats in order, pkt_cnt=1, grant_id=1.
REQ-030 All 3 sources request at once after reset, one beat each -> grant order 0,1,2, then 0 again if re-requested; pkt_cnt=3.
REQ-031 out_data_r toggles 1,0,1,0 during a 3-beat packet -> beats transfer only on ready cycles, src_data_r[g]=0 when ready is low, no beat duplicated or lost.
REQ-032 Source 0 eop_v lags data_v by 2 cycles -> no out beat until both are valid; data and eop leave together.
REQ-033 rst pulsed during beat 2 of a 5-beat packet -> busy=0 and pkt_cnt=0 next cycle; a new request from source 2 is granted first scanning from 0, i.e. source 2 when only it requests.
REQ-034 pkt_cnt forced or preloaded to 0xFFFFFFFF, one packet sent -> pkt_cnt=0.
